mem_op_sequencer: RTL and testbench
===================================

# mem_op_sequencer

Parametrised instruction sequencer that accepts one opcode at a time over a valid/ready handshake and drives memory read/write strobes or an ALU enable. Memory accesses have programmable wait states, sample a memory-ready handshake, and time out. Sits between the instruction source and the memory/ALU datapath. Replaces the fixed three-state read/write controller.

## Interface
Parameters:
- OPC_W, 3 — opcode width, ≥3. Encoding: FETCH=0, WRITE=1, ADD=2, SUB=3, MULT=4, DIV=5, SHIFT=6, NOP=7. Any value >7 is treated as NOP.
- WAIT_STATES, 1 — cycles, ≥0. Strobe is held for this many cycles before mem_ready is sampled.
- TIMEOUT, 16 — max mem_ready sample cycles, ≥1. Exceeding it aborts the access.

Ports:
- clock  in  1 — rising-edge clock.
- reset  in  1 — asynchronous, active-high reset.
- instr_valid  in  1 — instruction offered.
- instr_ready  out  1 — sequencer can accept. Equals (state==IDLE) and not reset.
- instruction  in  OPC_W — opcode. Captured when instr_valid and instr_ready are both high at a rising edge.
- mem_ready  in  1 — memory completes the current access.
- read  out  1 — memory read strobe.
- write  out  1 — memory write strobe.
- alu_en  out  1 — one-cycle ALU enable.
- alu_op  out  OPC_W — captured opcode. Valid while alu_en=1; 0 otherwise.
- busy  out  1 — state != IDLE.
- done  out  1 — one-cycle pulse on normal completion.
- timeout_err  out  1 — one-cycle pulse on access timeout.

## Operation
- States: IDLE, DECODE, LOAD, STORE, EXEC.
- IDLE: instr_ready=1. A handshake captures the opcode into op_q and moves to DECODE.
- DECODE, exactly 1 cycle, routes on op_q:
  - FETCH → LOAD
  - WRITE → STORE
  - 2..6 → EXEC
  - NOP or illegal → IDLE with done pulse
- LOAD: read=1. STORE: write=1.
  - Counter cnt is cleared on entry.
  - First WAIT_STATES cycles: mem_ready ignored.
  - After that, mem_ready is sampled each cycle.
  - mem_ready=1 → IDLE with done.
  - TIMEOUT consecutive samples with mem_ready=0 → IDLE with timeout_err, no done.
- EXEC: alu_en=1, alu_op=op_q for one cycle, then IDLE with done.
- read, write, alu_en are decoded from the state register only. They are mutually exclusive and never glitch on input changes.
- done and timeout_err are registered. They are high only in the first IDLE cycle after completion and are never high together.
- cnt width is clog2(WAIT_STATES+TIMEOUT+1). It saturates and never wraps.
- Reset (async, any state): state=IDLE, op_q=0, cnt=0.
  - All outputs 0: read, write, alu_en, alu_op, busy, done, timeout_err.
  - instr_ready=0 while reset is high.
  - Reset mid-access aborts silently: no done, no timeout_err.
- instruction and instr_valid are ignored outside IDLE. mem_ready is ignored outside LOAD/STORE.

## Timing
- Handshake at edge k. Cycle k+1 is DECODE, with busy=1 and instr_ready=0.
- LOAD/STORE timing:
  - Strobe high from cycle k+2.
  - mem_ready is first sampled at the end of cycle k+2+WAIT_STATES.
  - If mem_ready is high there, cycle k+3+WAIT_STATES is IDLE with done=1 and the strobe low.
  - Minimum strobe width is WAIT_STATES+1 cycles.
- Timeout: strobe is high for WAIT_STATES+TIMEOUT cycles. The next cycle is IDLE with timeout_err=1.
- EXEC: alu_en at k+2, done at k+3.
- NOP/illegal: done at k+2.
- Back-to-back: instr_ready=1 in the done/timeout_err cycle. A new instruction accepted at the end of that cycle starts DECODE the next cycle.
- mem_ready high on the last timeout sample counts as success (done, not timeout).

## Test plan
- Reset release, then FETCH (0) with WAIT_STATES=1 and mem_ready held high:
  - read high for exactly 2 cycles starting 2 cycles after acceptance.
  - done=1 one cycle later; busy low.
- WRITE (1) with mem_ready low for 3 sample cycles, then high:
  - write high for 1+3+1=5 cycles, then done.
  - read stays 0 throughout.
- FETCH with mem_ready stuck low, TIMEOUT=16:
  - read high 17 cycles, then timeout_err=1 and done=0.
  - The next instruction is accepted normally.
- Opcodes ADD..SHIFT (2..6) back-to-back, instr_valid held:
  - Each yields a one-cycle alu_en with alu_op matching the opcode.
  - One done per opcode; a new opcode is accepted every 3 cycles.
- NOP (7), and with OPC_W=4 the opcode 12:
  - done 2 cycles after acceptance.
  - No read, write, or alu_en asserted.
- Assert reset mid-LOAD (WAIT_STATES=3, cycle 2 of strobe):
  - read, busy, done, timeout_err are all 0 immediately, asynchronously.
  - instr_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/mem_op_sequencer.sv
// Opcode sequencer: accepts one opcode per valid/ready handshake and drives
// read/write strobes (with wait states, mem_ready sampling, timeout) or an ALU enable.
module mem_op_sequencer #(
  parameter int unsigned OPC_W       = 3,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPC_W-1:0] instruction,
  input  logic             mem_ready,
  output logic             read,
  output logic             write,
  output logic             alu_en,
  output logic [OPC_W-1:0] alu_op,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = $clog2(WAIT_STATES + TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WS_C    = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WAIT_STATES + TIMEOUT - 1);

  localparam logic [OPC_W-1:0] OP_FETCH = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_WRITE = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SHIFT = OPC_W'(6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_EXEC
  } state_t;

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (op_q == OP_FETCH)
          state_d = S_LOAD;
        else if (op_q == OP_WRITE)
          state_d = S_STORE;
        else if (op_q >= OP_ADD && op_q <= OP_SHIFT)
          state_d = S_EXEC;
        else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_LOAD, S_STORE: begin
        // cnt below WS_C counts ignored wait states; from WS_C on, each cycle is one sample
        if (cnt_q < WS_C)
          cnt_d = cnt_q + 1'b1;
        else if (mem_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q >= LAST_C) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + 1'b1;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE) && !reset;
    read        = (state_q == S_LOAD);
    write       = (state_q == S_STORE);
    alu_en      = (state_q == S_EXEC);
    alu_op      = (state_q == S_EXEC) ? op_q : '0;
    busy        = (state_q != S_IDLE);
    done        = done_q;
    timeout_err = tmo_q;
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Self-checking bench for mem_op_sequencer: two instances with different
// parameters, directed cases then randomized opcodes and memory latencies.
module tb_mem_op_sequencer;

  localparam int unsigned WS0 = 1;
  localparam int unsigned TO0 = 16;
  localparam int unsigned WS1 = 3;
  localparam int unsigned TO1 = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid [2];
  logic [3:0] instr [2];
  logic       mrdy  [2];
  logic       rdy   [2];
  logic       rd    [2];
  logic       wr    [2];
  logic       alu   [2];
  logic       bsy   [2];
  logic       dn    [2];
  logic       tmo   [2];
  logic [3:0] aop0;
  logic [2:0] aop1;
  logic [10:0] obs [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  mem_op_sequencer #(.OPC_W(4), .WAIT_STATES(WS0), .TIMEOUT(TO0)) u_seq0 (
    .clock(clock), .reset(reset), .instr_valid(valid[0]), .instr_ready(rdy[0]),
    .instruction(instr[0]), .mem_ready(mrdy[0]), .read(rd[0]), .write(wr[0]),
    .alu_en(alu[0]), .alu_op(aop0), .busy(bsy[0]), .done(dn[0]),
    .timeout_err(tmo[0])
  );

  mem_op_sequencer #(.OPC_W(3), .WAIT_STATES(WS1), .TIMEOUT(TO1)) u_seq1 (
    .clock(clock), .reset(reset), .instr_valid(valid[1]), .instr_ready(rdy[1]),
    .instruction(instr[1][2:0]), .mem_ready(mrdy[1]), .read(rd[1]), .write(wr[1]),
    .alu_en(alu[1]), .alu_op(aop1), .busy(bsy[1]), .done(dn[1]),
    .timeout_err(tmo[1])
  );

  assign obs[0] = {rdy[0], rd[0], wr[0], alu[0], aop0, bsy[0], dn[0], tmo[0]};
  assign obs[1] = {rdy[1], rd[1], wr[1], alu[1], {1'b0, aop1}, bsy[1], dn[1], tmo[1]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // {instr_ready, read, write, alu_en, alu_op[3:0], busy, done, timeout_err}
  function automatic logic [10:0] ev(input logic r, input logic rdx, input logic wrx,
                                     input logic al, input logic [3:0] op,
                                     input logic b, input logic d, input logic t);
    return {r, rdx, wrx, al, op, b, d, t};
  endfunction

  function automatic int unsigned ws_of(input int i);
    return (i == 0) ? WS0 : WS1;
  endfunction

  function automatic int unsigned to_of(input int i);
    return (i == 0) ? TO0 : TO1;
  endfunction

  task automatic junk(input int i);
    valid[i] = 1'($urandom);
    instr[i] = 4'($urandom);
    mrdy[i]  = 1'($urandom);
  endtask

  // Called at a negedge inside an IDLE cycle; returns at the negedge of the
  // completion cycle (which is again IDLE) with instr_valid dropped.
  // lat = number of low mem_ready samples before it goes high (>= TIMEOUT: never).
  task automatic run_op(input int i, input logic [3:0] op_in, input int unsigned lat);
    int unsigned ws   = ws_of(i);
    int unsigned to   = to_of(i);
    logic [3:0]  op   = (i == 0) ? op_in : (op_in & 4'h7);
    bit          is_rd = (op == 4'd0);
    bit          is_wr = (op == 4'd1);
    bit          is_ex = (op >= 4'd2 && op <= 4'd6);
    bit          ok    = 1'b1;
    check_eq("accept_ready", 32'(obs[i][10]), 32'd1);
    valid[i] = 1'b1;
    instr[i] = op_in;
    mrdy[i]  = 1'($urandom);
    @(negedge clock);
    check_eq("decode", 32'(obs[i]), 32'(ev(0, 0, 0, 0, 4'd0, 1, 0, 0)));
    junk(i);
    if (is_rd || is_wr) begin
      int unsigned nstb;
      ok   = (lat < to);
      nstb = ok ? (ws + lat + 1) : (ws + to);
      for (int unsigned j = 0; j < nstb; j++) begin
        @(negedge clock);
        check_eq(is_rd ? "read_strobe" : "write_strobe", 32'(obs[i]),
                 32'(ev(0, is_rd, is_wr, 0, 4'd0, 1, 0, 0)));
        junk(i);
        mrdy[i] = (j < ws) ? 1'($urandom) : ((j - ws) >= lat);
      end
    end else if (is_ex) begin
      @(negedge clock);
      check_eq("exec", 32'(obs[i]), 32'(ev(0, 0, 0, 1, op, 1, 0, 0)));
      junk(i);
    end
    @(negedge clock);
    check_eq(ok ? "done" : "timeout", 32'(obs[i]), 32'(ev(1, 0, 0, 0, 4'd0, 0, ok, !ok)));
    valid[i] = 1'b0;
    mrdy[i]  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      instr[i] = '0;
      mrdy[i]  = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check_eq("reset_dut0", 32'(obs[0]), 32'(ev(0, 0, 0, 0, 4'd0, 0, 0, 0)));
    check_eq("reset_dut1", 32'(obs[1]), 32'(ev(0, 0, 0, 0, 4'd0, 0, 0, 0)));
    reset = 1'b0;
    @(negedge clock);
    check_eq("idle_dut0", 32'(obs[0]), 32'(ev(1, 0, 0, 0, 4'd0, 0, 0, 0)));

    run_op(0, 4'd0, 0);
    run_op(0, 4'd1, 3);
    run_op(0, 4'd0, TO0);
    run_op(0, 4'd0, TO0 - 1);
    for (int op = 2; op <= 6; op++) run_op(0, 4'(op), 0);
    run_op(0, 4'd7, 0);
    run_op(0, 4'd12, 0);
    run_op(1, 4'd1, TO1);
    run_op(1, 4'd0, 0);

    // reset asserted during the second read-strobe cycle of DUT1
    valid[1] = 1'b1;
    instr[1] = 4'd0;
    @(negedge clock);
    valid[1] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("mid_load_read", 32'(obs[1]), 32'(ev(0, 1, 0, 0, 4'd0, 1, 0, 0)));
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset", 32'(obs[1]), 32'(ev(0, 0, 0, 0, 4'd0, 0, 0, 0)));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_reset_idle", 32'(obs[1]), 32'(ev(1, 0, 0, 0, 4'd0, 0, 0, 0)));
    run_op(1, 4'd1, 1);

    for (int n = 0; n < 80; n++) begin
      int          i   = int'($urandom_range(0, 1));
      logic [3:0]  op  = 4'($urandom);
      int unsigned lat = $urandom_range(0, to_of(i) + 1);
      run_op(i, op, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
